// File: rtl/dvs_row_packer.sv
// Packs sensor rows into {addr, event map} FIFO words and emits one header word per frame.
// Accept-to-write 2 cycles; headers wait out full_fifo indefinitely, rows drop after MAX_STALL full cycles.
module dvs_row_packer #(
    parameter int DWIDTH     = 136,
    parameter int MAX_STALL  = 4,
    parameter int SKIP_EMPTY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              frame_start,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [7:0]        row_addr,
    input  logic [127:0]      row_evt,
    input  logic              full_fifo,
    output logic              wr_en_fifo,
    output logic [DWIDTH-1:0] wdata_fifo,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              ovf_flag,
    input  logic              ovf_clr,
    output logic              busy
);

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] frame;
        logic [31:0] ts;
        logic [15:0] drops;
        logic [63:0] rsvd;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        ROW  = 2'd2
    } state_t;

    localparam logic [7:0]  HDR_TAG    = 8'hFF;
    localparam logic [15:0] STALL_LAST = 16'(MAX_STALL - 1);

    state_t              state_q, state_d;
    logic [31:0]         ts_q;
    logic [31:0]         hdr_ts_q, hdr_ts_d;
    logic                hdr_pend_q, hdr_pend_d;
    logic [7:0]          addr_q, addr_d;
    logic [127:0]        evt_q, evt_d;
    logic [15:0]         stall_q, stall_d;
    logic                wr_en_q, wr_en_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                ovf_q, ovf_d;
    logic                drop;
    logic                accept;
    hdr_t                hdr_word;

    // A frame_start pulse takes priority over a row offered in the same cycle.
    assign row_ready = en && (state_q == IDLE) && !hdr_pend_q && !frame_start;
    assign accept    = row_valid && row_ready;
    assign busy      = (state_q != IDLE) || hdr_pend_q;

    always_comb begin
        hdr_word       = '0;
        hdr_word.tag   = HDR_TAG;
        hdr_word.frame = frame_cnt_q;
        hdr_word.ts    = hdr_ts_q;
        hdr_word.drops = drop_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        hdr_ts_d    = hdr_ts_q;
        hdr_pend_d  = hdr_pend_q;
        addr_d      = addr_q;
        evt_d       = evt_q;
        stall_d     = stall_q;
        wr_en_d     = 1'b0;
        wdata_d     = wdata_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        drop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hdr_pend_q) begin
                    state_d = HDR;
                end else if (accept) begin
                    addr_d = row_addr;
                    evt_d  = row_evt;
                    if ((SKIP_EMPTY != 0) && (row_evt == '0)) begin
                        state_d = IDLE;
                    end else if (row_addr == HDR_TAG) begin
                        // Row index 0xFF would alias the header tag downstream.
                        drop = 1'b1;
                    end else begin
                        state_d = ROW;
                        stall_d = '0;
                    end
                end
            end
            HDR: begin
                if (!full_fifo) begin
                    wr_en_d     = 1'b1;
                    wdata_d     = DWIDTH'(hdr_word);
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    hdr_pend_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            ROW: begin
                if (!full_fifo) begin
                    wr_en_d = 1'b1;
                    wdata_d = DWIDTH'({addr_q, evt_q});
                    state_d = IDLE;
                end else if (stall_q == STALL_LAST) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame arriving as the previous header is written still gets its own header.
        if (frame_start) begin
            hdr_pend_d = 1'b1;
            hdr_ts_d   = ts_q;
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else if (en) begin
            ts_q <= ts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_ts_q    <= '0;
            hdr_pend_q  <= 1'b0;
            addr_q      <= '0;
            evt_q       <= '0;
            stall_q     <= '0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_ts_q    <= hdr_ts_d;
            hdr_pend_q  <= hdr_pend_d;
            addr_q      <= addr_d;
            evt_q       <= evt_d;
            stall_q     <= stall_d;
            wr_en_q     <= wr_en_d;
            wdata_q     <= wdata_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_en_fifo = wr_en_q;
    assign wdata_fifo = wdata_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_dvs_row_packer.sv
// Directed bench for dvs_row_packer: scoreboard of expected FIFO words plus literal checkpoints.
module tb_dvs_row_packer;

    localparam int MAX_STALL = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           frame_start;
    logic           row_valid;
    logic           row_ready;
    logic [7:0]     row_addr;
    logic [127:0]   row_evt;
    logic           full_fifo;
    logic           wr_en_fifo;
    logic [135:0]   wdata_fifo;
    logic [15:0]    frame_cnt;
    logic [15:0]    drop_cnt;
    logic           ovf_flag;
    logic           ovf_clr;
    logic           busy;

    int             checks   = 0;
    int             failures = 0;
    logic [135:0]   exp_q[$];
    int             hdr_seen;
    logic           prev_wr;
    logic           prev_full;
    logic [135:0]   last_hdr;
    logic [31:0]    m_ts;
    logic [31:0]    ts_a, ts_b;
    bit             ok;

    dvs_row_packer #(.DWIDTH(136), .MAX_STALL(MAX_STALL), .SKIP_EMPTY(1)) dut (
        .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
        .row_valid(row_valid), .row_ready(row_ready), .row_addr(row_addr),
        .row_evt(row_evt), .full_fifo(full_fifo), .wr_en_fifo(wr_en_fifo),
        .wdata_fifo(wdata_fifo), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts enabled cycles since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_ts <= '0;
        else if (en) m_ts <= m_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every write must be expected, in order, never back-to-back, and follow a non-full cycle.
    always @(negedge clk) begin
        if (rst) begin
            hdr_seen  = 0;
            prev_wr   = 1'b0;
            prev_full = 1'b0;
        end else begin
            if (wr_en_fifo) begin
                chk("wr_back_to_back", {135'd0, prev_wr}, 136'd0);
                chk("wr_after_full", {135'd0, prev_full}, 136'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%h required=none", wdata_fifo);
                end else begin
                    logic [135:0] w;
                    w = exp_q.pop_front();
                    chk("wdata", wdata_fifo, w);
                    if (w[135:128] == 8'hFF) begin
                        hdr_seen++;
                        last_hdr = wdata_fifo;
                    end
                end
            end
            chk("frame_cnt_track", {120'd0, frame_cnt}, {120'd0, hdr_seen[15:0]});
            prev_wr   = wr_en_fifo;
            prev_full = full_fifo;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [7:0] a, input logic [127:0] e, output bit acc_ok);
        logic acc;
        acc_ok    = 1'b0;
        row_valid = 1'b1;
        row_addr  = a;
        row_evt   = e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = row_ready;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            if (acc) begin
                acc_ok = 1'b1;
                break;
            end
        end
        row_valid = 1'b0;
        if (!acc_ok) begin
            checks++;
            failures++;
            $display("FAIL row_accept_timeout actual=no_handshake required=handshake addr=%h", a);
        end
    endtask

    // Holds full_fifo high for nfull decision cycles after acceptance.
    task automatic row_with_stall(input logic [7:0] a, input logic [127:0] e, input int nfull);
        bit acc_ok;
        full_fifo = (nfull > 0);
        if (nfull < MAX_STALL) exp_q.push_back({a, e});
        send_row(a, e, acc_ok);
        for (int i = 0; i < nfull; i++) @(posedge clk);
        #1;
        full_fifo = 1'b0;
        idle(6);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; frame_start = 1'b0; row_valid = 1'b0;
        row_addr = '0; row_evt = '0; full_fifo = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", {135'd0, wr_en_fifo}, 136'd0);
        chk("rst_wdata", wdata_fifo, 136'd0);
        chk("rst_frame_cnt", {120'd0, frame_cnt}, 136'd0);
        chk("rst_drop_cnt", {120'd0, drop_cnt}, 136'd0);
        chk("rst_ovf", {135'd0, ovf_flag}, 136'd0);
        chk("rst_busy", {135'd0, busy}, 136'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {135'd0, row_ready}, 136'd1);
        @(posedge clk); #1;

        // Basic row: latency 2, ready again 2 cycles after accept, data held afterwards.
        exp_q.push_back({8'h03, 128'h1});
        send_row(8'h03, 128'h1, ok);
        @(negedge clk);
        chk("t1_wr_n1", {135'd0, wr_en_fifo}, 136'd0);
        chk("t1_ready_n1", {135'd0, row_ready}, 136'd0);
        @(negedge clk);
        chk("t1_wr_n2", {135'd0, wr_en_fifo}, 136'd1);
        chk("t1_wdata", wdata_fifo, {8'h03, 128'h1});
        chk("t1_ready_n2", {135'd0, row_ready}, 136'd1);
        @(negedge clk);
        chk("t1_wr_n3", {135'd0, wr_en_fifo}, 136'd0);
        chk("t1_wdata_hold", wdata_fifo, {8'h03, 128'h1});
        @(posedge clk); #1;

        // frame_start at ts=100 together with a row: header goes out first.
        begin
            int g = 0;
            while (m_ts != 32'd100 && g < 1000) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 1000) begin
                checks++; failures++;
                $display("FAIL ts_wait actual=%0d required=100", m_ts);
            end
        end
        exp_q.push_back({8'hFF, 16'd0, 32'd100, 16'd0, 64'd0});
        exp_q.push_back({8'h07, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0077});
        frame_start = 1'b1;
        send_row(8'h07, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0077, ok);
        idle(6);
        chk("t2_frame_cnt", {120'd0, frame_cnt}, 136'd1);
        chk("t2_hdr_tag", {128'd0, last_hdr[135:128]}, 136'hFF);
        chk("t2_hdr_ts", {104'd0, last_hdr[111:80]}, 136'd100);

        // Held full: row dropped after MAX_STALL cycles, then cleared.
        row_with_stall(8'h05, 128'h55, 8);
        chk("t3_drop_cnt", {120'd0, drop_cnt}, 136'd1);
        chk("t3_ovf", {135'd0, ovf_flag}, 136'd1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t3_clr_drop", {120'd0, drop_cnt}, 136'd0);
        chk("t3_clr_ovf", {135'd0, ovf_flag}, 136'd0);
        @(posedge clk); #1;

        // Stall boundary: MAX_STALL-1 full cycles survive, MAX_STALL drop.
        row_with_stall(8'h06, 128'h66, MAX_STALL - 1);
        row_with_stall(8'h07, 128'h77, MAX_STALL);
        chk("bound_drop_cnt", {120'd0, drop_cnt}, 136'd1);
        row_with_stall(8'h08, 128'h88, 2);
        chk("t4_drop_cnt", {120'd0, drop_cnt}, 136'd1);

        // en dropped mid-ROW: word still completes, no new rows accepted.
        full_fifo = 1'b1;
        exp_q.push_back({8'h0A, 128'hAA});
        send_row(8'h0A, 128'hAA, ok);
        en = 1'b0;
        @(posedge clk); #1;
        full_fifo = 1'b0;
        @(negedge clk);
        chk("en0_ready", {135'd0, row_ready}, 136'd0);
        idle(4);
        chk("en0_drop_cnt", {120'd0, drop_cnt}, 136'd1);
        en = 1'b1;
        idle(2);

        // Header stuck behind full for 50 cycles; second frame_start retimes it.
        full_fifo = 1'b1;
        ts_a = m_ts;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        idle(20);
        ts_b = m_ts;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        idle(30);
        @(negedge clk);
        chk("t5_busy", {135'd0, busy}, 136'd1);
        chk("t5_ready", {135'd0, row_ready}, 136'd0);
        exp_q.push_back({8'hFF, 16'd1, ts_b, 16'd1, 64'd0});
        @(posedge clk); #1;
        full_fifo = 1'b0;
        idle(6);
        chk("t5_frame_cnt", {120'd0, frame_cnt}, 136'd2);
        chk("t5_hdr_ts", {104'd0, last_hdr[111:80]}, {104'd0, ts_b});
        chk("t5_ts_moved", {104'd0, ts_b - ts_a}, 136'd21);

        // Empty row consumed silently; 0xFF row dropped.
        send_row(8'h09, 128'h0, ok);
        chk("t6_empty_accepted", {135'd0, ok}, 136'd1);
        idle(4);
        send_row(8'hFF, 128'h1, ok);
        idle(2);
        chk("t6_ff_drop_cnt", {120'd0, drop_cnt}, 136'd2);
        chk("t6_ff_ovf", {135'd0, ovf_flag}, 136'd1);

        // Saturation: one drop per cycle from a continuous 0xFF stream.
        row_valid = 1'b1;
        row_addr  = 8'hFF;
        row_evt   = 128'h1;
        idle(65540);
        @(negedge clk);
        chk("sat_drop_cnt", {120'd0, drop_cnt}, 136'hFFFF);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr   = 1'b0;
        row_valid = 1'b0;
        @(negedge clk);
        chk("clr_and_drop_cnt", {120'd0, drop_cnt}, 136'd1);
        chk("clr_and_drop_ovf", {135'd0, ovf_flag}, 136'd1);
        @(posedge clk); #1;

        // Async reset while a write is on the bus.
        exp_q.push_back({8'h0B, 128'hBB});
        send_row(8'h0B, 128'hBB, ok);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_wr", {135'd0, wr_en_fifo}, 136'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_wr", {135'd0, wr_en_fifo}, 136'd0);
        chk("rst_mid_drop", {120'd0, drop_cnt}, 136'd0);
        chk("rst_mid_frame", {120'd0, frame_cnt}, 136'd0);
        chk("rst_mid_busy", {135'd0, busy}, 136'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        chk("queue_drained", 136'(exp_q.size()), 136'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
